// File: rtl/undolog_axi_pkg.sv
// Shared constants, FSM state type and burst-legality helper for the undo-log AXI burst slave.
package undolog_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam int unsigned BYTE_LANES = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WDATA = 2'd1,
        ST_WRESP = 2'd2,
        ST_RDATA = 2'd3
    } state_e;

    // Only FIXED and INCR are serviced; WRAP, reserved types and over-long bursts are errors.
    function automatic logic burst_bad(input logic [1:0] burst, input logic [7:0] len,
                                       input logic [8:0] max_len);
        return ((burst != BURST_FIXED) && (burst != BURST_INCR)) || ({1'b0, len} > max_len);
    endfunction

endpackage

// File: rtl/undolog_byte_ram.sv
// Word-addressed store with per-byte write enables and an asynchronous read port; never reset.
module undolog_byte_ram
    import undolog_axi_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 12
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [C_S_AXI_ADDR_WIDTH-3:0] waddr,
    input  logic [BYTE_LANES-1:0]         wstrb,
    input  logic [BYTE_LANES*8-1:0]       wdata,
    input  logic [C_S_AXI_ADDR_WIDTH-3:0] raddr,
    output logic [BYTE_LANES*8-1:0]       rdata
);
    localparam int DEPTH = 2 ** (C_S_AXI_ADDR_WIDTH - 2);

    logic [BYTE_LANES*8-1:0] mem [0:DEPTH-1];

    // Byte-lane write port.
    always_ff @(posedge clk) begin
        for (int b = 0; b < int'(BYTE_LANES); b++) begin
            if (we && wstrb[b]) begin
                mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/undolog_axi_burst_slave.sv
// AXI4 burst slave fronting a local word store; one write or read burst in flight at a time.
module undolog_axi_burst_slave
    import undolog_axi_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 12,
    parameter int C_S_AXI_MAX_LEN    = 255
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [7:0]                    S_AXI_AWLEN,
    input  logic [1:0]                    S_AXI_AWBURST,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WLAST,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [7:0]                    S_AXI_ARLEN,
    input  logic [1:0]                    S_AXI_ARBURST,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RLAST,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY
);
    localparam int         IW        = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [8:0] MAX_LEN_C = 9'(C_S_AXI_MAX_LEN);

    state_e                        state_q, state_d;
    logic [IW-1:0]                 idx_q, idx_d;
    logic [7:0]                    len_q, len_d, cnt_q, cnt_d;
    logic [1:0]                    burst_q, burst_d;
    logic                          err_q, err_d;
    logic                          awready_q, awready_d, arready_q, arready_d;
    logic                          wready_q, wready_d, bvalid_q, bvalid_d;
    logic [1:0]                    bresp_q, bresp_d, rresp_q, rresp_d;
    logic                          rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                          we_s, at_len_s, ar_err_s;
    logic [IW-1:0]                 raddr_s;
    logic [C_S_AXI_DATA_WIDTH-1:0] ram_rdata_s;
    logic                          unused_s;

    assign unused_s = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    undolog_byte_ram #(.C_S_AXI_ADDR_WIDTH(C_S_AXI_ADDR_WIDTH)) u_ram (
        .clk   (ACLK),
        .we    (we_s),
        .waddr (idx_q),
        .wstrb (S_AXI_WSTRB),
        .wdata (S_AXI_WDATA),
        .raddr (raddr_s),
        .rdata (ram_rdata_s)
    );

    // Read port looks at the AR start word while idle, otherwise at the next beat's word.
    always_comb begin
        raddr_s = idx_q;
        if (state_q == ST_IDLE) begin
            raddr_s = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
        end else if (burst_q == BURST_INCR) begin
            raddr_s = idx_q + IW'(1);
        end else begin
            raddr_s = idx_q;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;   idx_d     = idx_q;     len_d    = len_q;
        cnt_d     = cnt_q;     burst_d   = burst_q;   err_d    = err_q;
        awready_d = 1'b0;      arready_d = 1'b0;      wready_d = wready_q;
        bvalid_d  = bvalid_q;  bresp_d   = bresp_q;   rvalid_d = rvalid_q;
        rdata_d   = rdata_q;   rresp_d   = rresp_q;   rlast_d  = rlast_q;
        we_s      = 1'b0;
        at_len_s  = (cnt_q == len_q);
        ar_err_s  = burst_bad(S_AXI_ARBURST, S_AXI_ARLEN, MAX_LEN_C);
        case (state_q)
            ST_IDLE: begin
                if (awready_q && S_AXI_AWVALID) begin
                    idx_d    = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
                    len_d    = S_AXI_AWLEN;
                    burst_d  = S_AXI_AWBURST;
                    err_d    = burst_bad(S_AXI_AWBURST, S_AXI_AWLEN, MAX_LEN_C);
                    cnt_d    = 8'd0;
                    wready_d = 1'b1;
                    state_d  = ST_WDATA;
                end else if (arready_q && S_AXI_ARVALID) begin
                    idx_d    = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
                    len_d    = S_AXI_ARLEN;
                    burst_d  = S_AXI_ARBURST;
                    err_d    = ar_err_s;
                    cnt_d    = 8'd0;
                    rvalid_d = 1'b1;
                    rdata_d  = ar_err_s ? '0 : ram_rdata_s;
                    rresp_d  = ar_err_s ? RESP_SLVERR : RESP_OKAY;
                    rlast_d  = (S_AXI_ARLEN == 8'd0);
                    state_d  = ST_RDATA;
                end else if (!awready_q && !arready_q && S_AXI_AWVALID) begin
                    awready_d = 1'b1;
                end else if (!awready_q && !arready_q && S_AXI_ARVALID) begin
                    arready_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WDATA: begin
                if (wready_q && S_AXI_WVALID) begin
                    we_s  = !err_q;
                    err_d = err_q | (S_AXI_WLAST ^ at_len_s);
                    if (S_AXI_WLAST || at_len_s) begin
                        wready_d = 1'b0;
                        bvalid_d = 1'b1;
                        bresp_d  = (err_q | (S_AXI_WLAST ^ at_len_s)) ? RESP_SLVERR : RESP_OKAY;
                        state_d  = ST_WRESP;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                        idx_d = (burst_q == BURST_INCR) ? idx_q + IW'(1) : idx_q;
                    end
                end else begin
                    state_d = ST_WDATA;
                end
            end
            ST_WRESP: begin
                if (S_AXI_BREADY) begin
                    bvalid_d = 1'b0;
                    bresp_d  = RESP_OKAY;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_WRESP;
                end
            end
            ST_RDATA: begin
                if (S_AXI_RREADY && rlast_q) begin
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                    rdata_d  = '0;
                    rresp_d  = RESP_OKAY;
                    state_d  = ST_IDLE;
                end else if (S_AXI_RREADY) begin
                    cnt_d   = cnt_q + 8'd1;
                    idx_d   = raddr_s;
                    rdata_d = err_q ? '0 : ram_rdata_s;
                    rlast_d = ((cnt_q + 8'd1) == len_q);
                end else begin
                    state_d = ST_RDATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any burst in flight.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= ST_IDLE;  idx_q     <= '0;    len_q    <= 8'd0;
            cnt_q     <= 8'd0;     burst_q   <= 2'b00; err_q    <= 1'b0;
            awready_q <= 1'b0;     arready_q <= 1'b0;  wready_q <= 1'b0;
            bvalid_q  <= 1'b0;     bresp_q   <= 2'b00; rvalid_q <= 1'b0;
            rdata_q   <= '0;       rresp_q   <= 2'b00; rlast_q  <= 1'b0;
        end else begin
            state_q   <= state_d;   idx_q     <= idx_d;     len_q    <= len_d;
            cnt_q     <= cnt_d;     burst_q   <= burst_d;   err_q    <= err_d;
            awready_q <= awready_d; arready_q <= arready_d; wready_q <= wready_d;
            bvalid_q  <= bvalid_d;  bresp_q   <= bresp_d;   rvalid_q <= rvalid_d;
            rdata_q   <= rdata_d;   rresp_q   <= rresp_d;   rlast_q  <= rlast_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RLAST   = rlast_q;

endmodule

// File: tb/tb_undolog_axi_burst_slave.sv
// Directed self-checking bench for undolog_axi_burst_slave.
module tb_undolog_axi_burst_slave;
    import undolog_axi_pkg::*;

    logic        ACLK = 1'b0, ARESETN = 1'b0;
    logic [11:0] S_AXI_AWADDR = 12'h0, S_AXI_ARADDR = 12'h0;
    logic [7:0]  S_AXI_AWLEN = 8'd0, S_AXI_ARLEN = 8'd0;
    logic [1:0]  S_AXI_AWBURST = 2'b00, S_AXI_ARBURST = 2'b00;
    logic        S_AXI_AWVALID = 1'b0, S_AXI_ARVALID = 1'b0;
    logic [31:0] S_AXI_WDATA = 32'h0;
    logic [3:0]  S_AXI_WSTRB = 4'h0;
    logic        S_AXI_WLAST = 1'b0, S_AXI_WVALID = 1'b0;
    logic        S_AXI_BREADY = 1'b0, S_AXI_RREADY = 1'b0;
    logic        S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY;
    logic        S_AXI_RLAST, S_AXI_RVALID;
    logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
    logic [31:0] S_AXI_RDATA;

    int total = 0;
    int bad   = 0;

    logic [31:0] wdata_v [16];
    logic [3:0]  strb_v  [16];
    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    int          rd_beats;
    int          stall_err;

    undolog_axi_burst_slave dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN), .S_AXI_AWBURST(S_AXI_AWBURST),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN), .S_AXI_ARBURST(S_AXI_ARBURST),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RLAST(S_AXI_RLAST),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
    );

    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Full write burst using wdata_v/strb_v; WLAST is driven on beat wlast_at.
    task automatic axi_write(input logic [11:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input int wlast_at, output logic [1:0] resp, output int beats,
                             output bit gotb);
        int n;
        beats = 0; gotb = 1'b0; resp = 2'b11; n = 0;
        S_AXI_AWADDR = addr; S_AXI_AWLEN = len; S_AXI_AWBURST = burst; S_AXI_AWVALID = 1'b1;
        while (!S_AXI_AWREADY && n < 20) begin tick(); n++; end
        tick();
        S_AXI_AWVALID = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (S_AXI_BVALID || beats >= 16) break;
            if (S_AXI_WREADY) begin
                S_AXI_WVALID = 1'b1; S_AXI_WDATA = wdata_v[beats]; S_AXI_WSTRB = strb_v[beats];
                S_AXI_WLAST = (beats == wlast_at);
                tick();
                beats++;
            end else begin
                S_AXI_WVALID = 1'b0;
                tick();
            end
        end
        S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
        gotb = S_AXI_BVALID;
        if (gotb) begin
            resp = S_AXI_BRESP;
            S_AXI_BREADY = 1'b1;
            tick();
            S_AXI_BREADY = 1'b0;
        end
    endtask

    // Full read burst; when stall is set RREADY follows the pattern 1,0,0,1 repeating.
    task automatic axi_read(input logic [11:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input bit stall);
        int n;
        bit was_stall, fin, rr;
        logic [31:0] snap_d;
        logic [1:0]  snap_r;
        logic        snap_l;
        rd_beats = 0; stall_err = 0; n = 0; was_stall = 1'b0;
        snap_d = 32'h0; snap_r = 2'b00; snap_l = 1'b0;
        for (int i = 0; i < 16; i++) begin rd_data[i] = 32'hx; rd_resp[i] = 2'bx; rd_last[i] = 1'bx; end
        S_AXI_ARADDR = addr; S_AXI_ARLEN = len; S_AXI_ARBURST = burst; S_AXI_ARVALID = 1'b1;
        while (!S_AXI_ARREADY && n < 20) begin tick(); n++; end
        tick();
        S_AXI_ARVALID = 1'b0;
        for (int c = 0; c < 80; c++) begin
            if (was_stall && (!S_AXI_RVALID || S_AXI_RDATA !== snap_d || S_AXI_RLAST !== snap_l ||
                              S_AXI_RRESP !== snap_r)) stall_err++;
            rr = stall ? ((c % 4) == 0 || (c % 4) == 3) : 1'b1;
            S_AXI_RREADY = rr;
            was_stall = S_AXI_RVALID && !rr;
            snap_d = S_AXI_RDATA; snap_l = S_AXI_RLAST; snap_r = S_AXI_RRESP;
            fin = 1'b0;
            if (S_AXI_RVALID && rr && rd_beats < 16) begin
                rd_data[rd_beats] = S_AXI_RDATA; rd_resp[rd_beats] = S_AXI_RRESP;
                rd_last[rd_beats] = S_AXI_RLAST;
                rd_beats++;
                fin = S_AXI_RLAST;
            end
            tick();
            if (fin) break;
        end
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP, S_AXI_ARREADY, S_AXI_RVALID,
             S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST} !== 41'h0) begin
            bad++;
            $display("FAIL reset_outputs: got aw=%b w=%b b=%b ar=%b r=%b rdata=%h want all 0",
                     S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RDATA);
        end
    endtask

    task automatic test_incr();
        logic [1:0] resp; int beats; bit gotb;
        for (int i = 0; i < 4; i++) begin wdata_v[i] = 32'(i + 1); strb_v[i] = 4'hF; end
        axi_write(12'h000, 8'd3, BURST_INCR, 3, resp, beats, gotb);
        total++;
        if (!gotb || resp !== 2'b00 || beats != 4) begin
            bad++; $display("FAIL incr_write: got b=%0d resp=%b beats=%0d want 1 00 4", gotb, resp, beats);
        end
        axi_read(12'h000, 8'd3, BURST_INCR, 1'b0);
        total++;
        if (rd_beats != 4) begin bad++; $display("FAIL incr_read_beats: got %0d want 4", rd_beats); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rd_data[i] !== 32'(i + 1) || rd_resp[i] !== 2'b00 || rd_last[i] !== (i == 3)) begin
                bad++;
                $display("FAIL incr_read_beat%0d: got %h/%b/%b want %h/00/%b", i, rd_data[i], rd_resp[i],
                         rd_last[i], 32'(i + 1), (i == 3));
            end
        end
    endtask

    task automatic test_fixed();
        logic [1:0] resp; int beats; bit gotb;
        wdata_v[0] = 32'hAABBCCDD; strb_v[0] = 4'hF;
        wdata_v[1] = 32'h11223344; strb_v[1] = 4'h3;
        axi_write(12'h010, 8'd1, BURST_FIXED, 1, resp, beats, gotb);
        total++;
        if (!gotb || resp !== 2'b00 || beats != 2) begin
            bad++; $display("FAIL fixed_write: got b=%0d resp=%b beats=%0d want 1 00 2", gotb, resp, beats);
        end
        axi_read(12'h010, 8'd0, BURST_INCR, 1'b0);
        total++;
        if (rd_data[0] !== 32'hAABB3344 || rd_last[0] !== 1'b1) begin
            bad++; $display("FAIL fixed_read: got %h last=%b want aabb3344 last=1", rd_data[0], rd_last[0]);
        end
    endtask

    task automatic test_wrap();
        logic [1:0] resp; int beats; bit gotb;
        for (int i = 0; i < 4; i++) begin wdata_v[i] = 32'h50 + 32'(i); strb_v[i] = 4'hF; end
        axi_write(12'h020, 8'd3, BURST_INCR, 3, resp, beats, gotb);
        for (int i = 0; i < 4; i++) wdata_v[i] = 32'hDEAD0000 + 32'(i);
        axi_write(12'h020, 8'd3, BURST_WRAP, 3, resp, beats, gotb);
        total++;
        if (!gotb || resp !== 2'b10 || beats != 4) begin
            bad++; $display("FAIL wrap_write: got b=%0d resp=%b beats=%0d want 1 10 4", gotb, resp, beats);
        end
        axi_read(12'h020, 8'd3, BURST_INCR, 1'b0);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rd_data[i] !== 32'h50 + 32'(i)) begin
                bad++; $display("FAIL wrap_mem_unchanged%0d: got %h want %h", i, rd_data[i], 32'h50 + 32'(i));
            end
        end
        axi_read(12'h020, 8'd3, BURST_WRAP, 1'b0);
        total++;
        if (rd_beats != 4) begin bad++; $display("FAIL wrap_read_beats: got %0d want 4", rd_beats); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rd_data[i] !== 32'h0 || rd_resp[i] !== 2'b10 || rd_last[i] !== (i == 3)) begin
                bad++;
                $display("FAIL wrap_read_beat%0d: got %h/%b/%b want 0/10/%b", i, rd_data[i], rd_resp[i],
                         rd_last[i], (i == 3));
            end
        end
    endtask

    task automatic test_wlast_early();
        logic [1:0] resp; int beats; bit gotb;
        for (int i = 0; i < 4; i++) begin wdata_v[i] = 32'h60 + 32'(i); strb_v[i] = 4'hF; end
        axi_write(12'h040, 8'd3, BURST_INCR, 1, resp, beats, gotb);
        total++;
        if (!gotb || resp !== 2'b10 || beats != 2) begin
            bad++; $display("FAIL wlast_early: got b=%0d resp=%b beats=%0d want 1 10 2", gotb, resp, beats);
        end
    endtask

    task automatic test_priority();
        bit ar_early; int n;
        S_AXI_AWADDR = 12'h060; S_AXI_AWLEN = 8'd0; S_AXI_AWBURST = BURST_INCR; S_AXI_AWVALID = 1'b1;
        S_AXI_ARADDR = 12'h060; S_AXI_ARLEN = 8'd0; S_AXI_ARBURST = BURST_INCR; S_AXI_ARVALID = 1'b1;
        tick();
        total++;
        if ({S_AXI_AWREADY, S_AXI_ARREADY} !== 2'b10) begin
            bad++; $display("FAIL prio_aw_first: got aw=%b ar=%b want 1 0", S_AXI_AWREADY, S_AXI_ARREADY);
        end
        tick();
        S_AXI_AWVALID = 1'b0;
        ar_early = S_AXI_ARREADY;
        S_AXI_WVALID = 1'b1; S_AXI_WDATA = 32'h00000077; S_AXI_WSTRB = 4'hF; S_AXI_WLAST = 1'b1;
        tick();
        S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
        ar_early |= S_AXI_ARREADY;
        total++;
        if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== 2'b00) begin
            bad++; $display("FAIL prio_bresp: got bvalid=%b resp=%b want 1 00", S_AXI_BVALID, S_AXI_BRESP);
        end
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        ar_early |= S_AXI_ARREADY;
        total++;
        if (ar_early !== 1'b0) begin bad++; $display("FAIL prio_ar_wait: got early=1 want 0"); end
        n = 0;
        while (!S_AXI_ARREADY && n < 10) begin tick(); n++; end
        total++;
        if (S_AXI_ARREADY !== 1'b1) begin bad++; $display("FAIL prio_ar_accept: got 0 want 1"); end
        tick();
        S_AXI_ARVALID = 1'b0;
        total++;
        if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'h77 || S_AXI_RLAST !== 1'b1) begin
            bad++; $display("FAIL prio_read_after_write: got v=%b %h last=%b want 1 00000077 1",
                            S_AXI_RVALID, S_AXI_RDATA, S_AXI_RLAST);
        end
        S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_RREADY = 1'b0;
        total++;
        if (S_AXI_RVALID !== 1'b0) begin bad++; $display("FAIL prio_rvalid_drop: got 1 want 0"); end
    endtask

    task automatic test_stall();
        logic [1:0] resp; int beats; bit gotb;
        for (int i = 0; i < 8; i++) begin wdata_v[i] = 32'h100 + 32'(i); strb_v[i] = 4'hF; end
        axi_write(12'h100, 8'd7, BURST_INCR, 7, resp, beats, gotb);
        axi_read(12'h100, 8'd7, BURST_INCR, 1'b1);
        total++;
        if (rd_beats != 8 || stall_err != 0) begin
            bad++; $display("FAIL stall_read: got beats=%0d stall_err=%0d want 8 0", rd_beats, stall_err);
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (rd_data[i] !== 32'h100 + 32'(i) || rd_last[i] !== (i == 7)) begin
                bad++; $display("FAIL stall_beat%0d: got %h last=%b want %h last=%b", i, rd_data[i],
                                rd_last[i], 32'h100 + 32'(i), (i == 7));
            end
        end
    endtask

    task automatic test_addr_wrap();
        logic [1:0] resp; int beats; bit gotb;
        wdata_v[0] = 32'hCAFE0001; wdata_v[1] = 32'hCAFE0002; strb_v[0] = 4'hF; strb_v[1] = 4'hF;
        axi_write(12'hFFC, 8'd1, BURST_INCR, 1, resp, beats, gotb);
        total++;
        if (!gotb || resp !== 2'b00) begin
            bad++; $display("FAIL addrwrap_write: got b=%0d resp=%b want 1 00", gotb, resp);
        end
        axi_read(12'h000, 8'd0, BURST_INCR, 1'b0);
        total++;
        if (rd_data[0] !== 32'hCAFE0002) begin
            bad++; $display("FAIL addrwrap_low: got %h want cafe0002", rd_data[0]);
        end
        axi_read(12'hFFC, 8'd0, BURST_INCR, 1'b0);
        total++;
        if (rd_data[0] !== 32'hCAFE0001) begin
            bad++; $display("FAIL addrwrap_high: got %h want cafe0001", rd_data[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] resp; int beats; bit gotb; int b_seen;
        S_AXI_AWADDR = 12'h200; S_AXI_AWLEN = 8'd7; S_AXI_AWBURST = BURST_INCR; S_AXI_AWVALID = 1'b1;
        tick(); tick();
        S_AXI_AWVALID = 1'b0;
        for (int i = 0; i < 2; i++) begin
            S_AXI_WVALID = 1'b1; S_AXI_WDATA = 32'(i); S_AXI_WSTRB = 4'hF; S_AXI_WLAST = 1'b0;
            tick();
        end
        total++;
        if (S_AXI_WREADY !== 1'b1) begin bad++; $display("FAIL midrst_inburst: got wready=0 want 1"); end
        S_AXI_WDATA = 32'h2;
        #2 ARESETN = 1'b0;
        #1;
        total++;
        if ({S_AXI_WREADY, S_AXI_BVALID} !== 2'b00) begin
            bad++; $display("FAIL midrst_async: got wready=%b bvalid=%b want 0 0", S_AXI_WREADY, S_AXI_BVALID);
        end
        S_AXI_WVALID = 1'b0;
        tick(); tick();
        ARESETN = 1'b1;
        b_seen = 0;
        for (int i = 0; i < 6; i++) begin tick(); if (S_AXI_BVALID) b_seen++; end
        total++;
        if (b_seen != 0) begin bad++; $display("FAIL midrst_no_b: got %0d cycles of bvalid want 0", b_seen); end
        wdata_v[0] = 32'h0BAD0001; strb_v[0] = 4'hF;
        axi_write(12'h200, 8'd0, BURST_INCR, 0, resp, beats, gotb);
        total++;
        if (!gotb || resp !== 2'b00 || beats != 1) begin
            bad++; $display("FAIL midrst_next_aw: got b=%0d resp=%b beats=%0d want 1 00 1", gotb, resp, beats);
        end
    endtask

    initial begin
        repeat (3) tick();
        test_reset();
        ARESETN = 1'b1;
        tick();
        test_incr();
        test_fixed();
        test_wrap();
        test_wlast_early();
        test_priority();
        test_stall();
        test_addr_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/undolog_axi_burst_slave.md
Name: undolog_axi_burst_slave

Overview:
- AXI4 memory-mapped slave that services the undo-log engine's M0x_AXI burst masters.
- Provides a local word-addressed log/data store for INCR and FIXED bursts.
- Sits on the far end of each master port, standing in for the slave_N memory endpoints in the undolog block design.
- Handles one transaction at a time: write burst or read burst, never both.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; fixed full-width beats (4 bytes)
C_S_AXI_ADDR_WIDTH, 12, byte address width; memory holds 2**(C_S_AXI_ADDR_WIDTH-2) words
C_S_AXI_MAX_LEN, 255, largest accepted AxLEN; larger bursts get SLVERR

Ports:
ACLK  in  1  clock
ARESETN  in  1  reset, asynchronous, active-low
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write burst start address
S_AXI_AWLEN  in  8  write beats minus one
S_AXI_AWBURST  in  2  burst type
S_AXI_AWVALID  in  1  AW valid
S_AXI_AWREADY  out  1  AW ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WLAST  in  1  last write beat
S_AXI_WVALID  in  1  W valid
S_AXI_WREADY  out  1  W ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  B valid
S_AXI_BREADY  in  1  B ready
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read burst start address
S_AXI_ARLEN  in  8  read beats minus one
S_AXI_ARBURST  in  2  burst type
S_AXI_ARVALID  in  1  AR valid
S_AXI_ARREADY  out  1  AR ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RLAST  out  1  last read beat
S_AXI_RVALID  out  1  R valid
S_AXI_RREADY  in  1  R ready

Behaviour:
- Reset (ARESETN low, asynchronous, also mid-burst): all outputs 0, state IDLE, beat counter 0, error flag 0.
  - Memory contents are not reset.
  - Any in-flight burst is abandoned, with no B or R response after reset release.
- FSM states: IDLE, WDATA, WRESP, RDATA.
- IDLE:
  - If AWVALID, pulse AWREADY for one cycle and latch addr/len/burst, then go to WDATA.
  - Else if ARVALID, pulse ARREADY for one cycle, latch, then go to RDATA.
  - Write has priority when both valids are high in the same cycle; AR stays pending.
- Address rules:
  - Word index = addr[C_S_AXI_ADDR_WIDTH-1:2]; low 2 bits are ignored.
  - INCR: index +1 per beat, wrapping modulo memory depth with no error.
  - FIXED: index held.
  - WRAP or reserved burst type, or len > C_S_AXI_MAX_LEN: error flag set.
- WDATA:
  - WREADY high continuously, starting the cycle after the AW handshake.
  - Each W handshake writes the bytes enabled by WSTRB, unless the error flag is set, in which case data is discarded.
  - Beat counter runs 0..len.
  - Burst ends on the handshake where count==len OR WLAST=1, whichever comes first.
  - WLAST mismatch (WLAST at count<len, or WLAST=0 at count==len) sets SLVERR.
  - At burst end: WREADY low and go to WRESP.
- WRESP:
  - BVALID high the cycle after the final W handshake.
  - BRESP = SLVERR if error flag set, else OKAY.
  - Hold until BREADY, then return to IDLE (BVALID low the next cycle).
- RDATA:
  - RVALID high the cycle after the AR handshake.
  - RDATA is a registered copy of mem[index]; RLAST=1 only on beat len.
  - On an R handshake: advance to the next beat, with RVALID staying high, giving one beat per cycle while RREADY=1.
  - On the RLAST handshake: go to IDLE.
  - While RVALID=1 and RREADY=0, RDATA/RRESP/RLAST hold stable.
- Read error: RDATA=0 and RRESP=SLVERR on every beat; full len+1 beats are still returned.
- Write/read ordering: a read accepted after a write's B handshake observes that write's data.

Decomposition:
- Package undolog_axi_pkg holds:
  - resp constants OKAY=2'b00, SLVERR=2'b10;
  - burst constants FIXED=2'b00, INCR=2'b01, WRAP=2'b10;
  - state enum for the FSM;
  - byte-lane count constant.
- Sub-module undolog_byte_ram: one write port with 4 byte enables and one asynchronous read port, sized by C_S_AXI_ADDR_WIDTH.

Test Plan:
- Write INCR addr 0x000, len 3, data 1,2,3,4, WSTRB 0xF, WLAST on beat 3 -> BRESP OKAY. Then read INCR addr 0x000, len 3 -> RDATA 1,2,3,4, RLAST on 4th beat, RRESP OKAY.
- Write FIXED addr 0x010, len 1, data 0xAABBCCDD then 0x11223344 with WSTRB 0x3 -> read 0x010 returns 0xAABB3344.
- WRAP write addr 0x020 len 3 -> 4 beats accepted, BRESP SLVERR, memory unchanged. WRAP read -> 4 beats of 0, SLVERR, RLAST on 4th.
- WLAST on beat 1 of len 3 -> burst ends after 2 beats, BRESP SLVERR. Then AWVALID and ARVALID high together -> AWREADY pulses first, ARREADY only after the B handshake.
- Read len 7 with RREADY toggling 1,0,0,1,… -> RDATA stable during stalls, 8 beats delivered in order. INCR write from 0xFFC, len 1 -> second beat lands at 0x000.
- ARESETN low mid-write (beat 2 of len 7) -> WREADY/BVALID 0 immediately. After release: no BVALID, next AW accepted from IDLE.
